// File: rtl/camera_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration block.
// Table entries are {register address, value}; two reserved codes mark END and DELAY.
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } cfg_state_t;

  localparam logic [15:0] CAM_CFG_END   = 16'hFFFF;
  localparam logic [15:0] CAM_CFG_DELAY = 16'hFFF0;

  // OV7670 register addresses used by the setup table
  localparam logic [7:0] REG_VREF   = 8'h03;
  localparam logic [7:0] REG_COM1   = 8'h04;
  localparam logic [7:0] REG_COM3   = 8'h0C;
  localparam logic [7:0] REG_CLKRC  = 8'h11;
  localparam logic [7:0] REG_COM7   = 8'h12;
  localparam logic [7:0] REG_COM9   = 8'h14;
  localparam logic [7:0] REG_COM10  = 8'h15;
  localparam logic [7:0] REG_HSTART = 8'h17;
  localparam logic [7:0] REG_HSTOP  = 8'h18;
  localparam logic [7:0] REG_VSTRT  = 8'h19;
  localparam logic [7:0] REG_VSTOP  = 8'h1A;
  localparam logic [7:0] REG_HREF   = 8'h32;
  localparam logic [7:0] REG_TSLB   = 8'h3A;
  localparam logic [7:0] REG_COM14  = 8'h3E;
  localparam logic [7:0] REG_COM15  = 8'h40;
  localparam logic [7:0] REG_RGB444 = 8'h8C;

  function automatic logic [15:0] cfg_entry(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/camera_config_rom.sv
// Registered lookup of the SCCB register table. TABLE_SEL 0 is the real OV7670
// RGB565 VGA setup; 1 and 2 are tiny single-entry tables for bring-up checks.
module camera_config_rom
  import camera_pkg::*;
#(
  parameter int TABLE_SEL = 0
) (
  input  logic        clk_65mhz,
  input  logic [7:0]  index,
  output logic [15:0] entry
);

  logic [15:0] entry_d;

  always_comb begin
    entry_d = CAM_CFG_END;
    if (TABLE_SEL == 1) begin
      if (index == 8'd0) entry_d = cfg_entry(REG_COM7, 8'h80);
    end else if (TABLE_SEL == 2) begin
      if (index == 8'd0) entry_d = CAM_CFG_DELAY;
    end else begin
      // Soft reset first, then let the sensor settle before the real setup
      case (index)
        8'd0:    entry_d = cfg_entry(REG_COM7, 8'h80);
        8'd1:    entry_d = CAM_CFG_DELAY;
        8'd2:    entry_d = cfg_entry(REG_CLKRC, 8'h01);
        8'd3:    entry_d = cfg_entry(REG_COM7, 8'h04);
        8'd4:    entry_d = cfg_entry(REG_COM3, 8'h00);
        8'd5:    entry_d = cfg_entry(REG_COM14, 8'h00);
        8'd6:    entry_d = cfg_entry(REG_RGB444, 8'h00);
        8'd7:    entry_d = cfg_entry(REG_COM1, 8'h00);
        8'd8:    entry_d = cfg_entry(REG_COM15, 8'hD0);
        8'd9:    entry_d = cfg_entry(REG_TSLB, 8'h04);
        8'd10:   entry_d = cfg_entry(REG_COM9, 8'h18);
        8'd11:   entry_d = cfg_entry(REG_HSTART, 8'h13);
        8'd12:   entry_d = cfg_entry(REG_HSTOP, 8'h01);
        8'd13:   entry_d = cfg_entry(REG_HREF, 8'hB6);
        8'd14:   entry_d = cfg_entry(REG_VSTRT, 8'h02);
        8'd15:   entry_d = cfg_entry(REG_VSTOP, 8'h7A);
        8'd16:   entry_d = cfg_entry(REG_VREF, 8'h0A);
        8'd17:   entry_d = cfg_entry(REG_COM10, 8'h00);
        default: entry_d = CAM_CFG_END;
      endcase
    end
  end

  always_ff @(posedge clk_65mhz) begin
    entry <= entry_d;
  end

endmodule

// File: rtl/camera_sccb_config.sv
// Walks the OV7670 register table and issues one 3-byte SCCB write per entry.
// SIOD is open-drain: siod_drive_out=1 pulls the line low, 0 releases it.
module camera_sccb_config
  import camera_pkg::*;
#(
  parameter int         CLK_HZ       = 65_000_000,
  parameter int         SCCB_HZ      = 100_000,
  parameter logic [7:0] DEVICE_ID    = 8'h42,
  parameter int         DELAY_CYCLES = 650_000,
  parameter int         TABLE_SEL    = 0
) (
  input  logic system_clock_in,
  input  logic reset_in,
  input  logic start_in,
  input  logic siod_in,
  output logic sioc_out,
  output logic siod_drive_out,
  output logic busy_out,
  output logic done_out,
  output logic ack_error_out
);

  localparam int QUARTER_RAW = CLK_HZ / (4 * SCCB_HZ);
  localparam int QUARTER     = (QUARTER_RAW < 1) ? 1 : QUARTER_RAW;
  localparam int CNT_MAX     = (QUARTER > DELAY_CYCLES) ? QUARTER : DELAY_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] QUARTER_LAST = CNT_W'(QUARTER - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);

  logic             clk_65mhz;
  cfg_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       qidx, qidx_d;
  logic [4:0]       bit_cnt, bit_cnt_d;
  logic [26:0]      shift, shift_d;
  logic [7:0]       index, index_d;
  logic             ack_err, ack_err_d;
  logic [15:0]      rom_entry;
  logic             tick;
  logic             ack_slot;

  assign clk_65mhz = system_clock_in;

  // The ROM is addressed with the next index so the entry is ready during LOAD
  camera_config_rom #(.TABLE_SEL(TABLE_SEL)) u_rom (
    .clk_65mhz (clk_65mhz),
    .index     (index_d),
    .entry     (rom_entry)
  );

  assign tick     = (cnt == QUARTER_LAST);
  assign ack_slot = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);

  always_comb begin
    state_d        = state;
    qidx_d         = qidx;
    bit_cnt_d      = bit_cnt;
    shift_d        = shift;
    index_d        = index;
    ack_err_d      = ack_err;
    sioc_out       = 1'b1;
    siod_drive_out = 1'b0;
    if (tick) begin
      cnt_d  = '0;
      qidx_d = qidx + 2'd1;
    end else begin
      cnt_d = cnt + 1'b1;
    end

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          state_d   = ST_LOAD;
          index_d   = 8'd0;
          ack_err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = 5'd0;
        if (rom_entry == CAM_CFG_END) begin
          state_d = ST_DONE;
        end else if (rom_entry == CAM_CFG_DELAY) begin
          state_d = ST_WAIT;
        end else begin
          shift_d = {DEVICE_ID, 1'b1, rom_entry[15:8], 1'b1, rom_entry[7:0], 1'b1};
          state_d = ST_START;
        end
      end
      ST_START: begin
        sioc_out       = (qidx == 2'd0);
        siod_drive_out = 1'b1;
        if (tick && qidx == 2'd1) state_d = ST_BITS;
      end
      ST_BITS: begin
        // ACK slots carry a 1 in the shift register, which releases SIOD
        sioc_out       = qidx[1];
        siod_drive_out = ~shift[26];
        if (tick && qidx == 2'd2 && ack_slot && siod_in) ack_err_d = 1'b1;
        if (tick && qidx == 2'd3) begin
          if (bit_cnt == 5'd26) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
            shift_d   = {shift[25:0], 1'b0};
          end
        end
      end
      ST_STOP: begin
        sioc_out       = (qidx != 2'd0);
        siod_drive_out = (qidx != 2'd2);
        if (tick && qidx == 2'd2) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (tick && qidx == 2'd3) begin
          state_d = ST_LOAD;
          index_d = index + 8'd1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == DELAY_LAST) begin
          state_d = ST_LOAD;
          index_d = index + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state) begin
      cnt_d  = '0;
      qidx_d = 2'd0;
    end
  end

  always_ff @(posedge clk_65mhz) begin
    if (reset_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      qidx    <= 2'd0;
      bit_cnt <= 5'd0;
      shift   <= '0;
      index   <= 8'd0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      qidx    <= qidx_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      index   <= index_d;
      ack_err <= ack_err_d;
    end
  end

  assign busy_out      = (state != ST_IDLE) && (state != ST_DONE);
  assign done_out      = (state == ST_DONE);
  assign ack_error_out = ack_err;

endmodule
